// File: rtl/cond_pkg.sv
// Shared definitions for the input conditioning stages: FSM states and counter width.
package cond_pkg;

  localparam int CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } cond_state_t;

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle of the raw input and the conditioned outputs of input_conditioner.
interface input_conditioner_if;
  import cond_pkg::*;

  logic                 D_raw;
  logic                 Q_clean;
  logic                 Rise;
  logic                 Fall;
  logic [CNT_WIDTH-1:0] Edge_count;

  modport master (output D_raw, input Q_clean, Rise, Fall, Edge_count);
  modport slave  (input D_raw, output Q_clean, Rise, Fall, Edge_count);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the Clk domain.
module sync_2ff (
  input  logic Clk,
  input  logic Reset,
  input  logic D,
  output logic Q
);

  logic stage;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stage <= 1'b0;
      Q     <= 1'b0;
    end else begin
      stage <= D;
      Q     <= stage;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw switch input, producing a clean level,
// one-cycle edge pulses and a wrapping count of accepted rising edges.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                Clk,
  input logic                Reset,
  input_conditioner_if.slave bus
);
  import cond_pkg::*;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic                 s;
  cond_state_t          state;
  logic [CNT_WIDTH-1:0] counter;
  logic                 q;
  logic                 rise;
  logic                 fall;
  logic [CNT_WIDTH-1:0] edge_count;

  sync_2ff u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .D     (bus.D_raw),
    .Q     (s)
  );

  // A single-cycle debounce has no WAIT phase: the first differing sample is accepted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= STABLE_LOW;
      counter    <= '0;
      q          <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      edge_count <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          counter <= '0;
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state      <= STABLE_HIGH;
              q          <= 1'b1;
              rise       <= 1'b1;
              edge_count <= edge_count + ONE;
            end else begin
              state   <= WAIT_HIGH;
              counter <= ONE;
            end
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state   <= STABLE_LOW;
            counter <= '0;
          end else if (counter == LAST) begin
            state      <= STABLE_HIGH;
            counter    <= '0;
            q          <= 1'b1;
            rise       <= 1'b1;
            edge_count <= edge_count + ONE;
          end else begin
            counter <= counter + ONE;
          end
        end
        STABLE_HIGH: begin
          counter <= '0;
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= STABLE_LOW;
              q     <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state   <= WAIT_LOW;
              counter <= ONE;
            end
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state   <= STABLE_HIGH;
            counter <= '0;
          end else if (counter == LAST) begin
            state   <= STABLE_LOW;
            counter <= '0;
            q       <= 1'b0;
            fall    <= 1'b1;
          end else begin
            counter <= counter + ONE;
          end
        end
        default: begin
          state   <= STABLE_LOW;
          counter <= '0;
          q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q_clean    = q;
  assign bus.Rise       = rise;
  assign bus.Fall       = fall;
  assign bus.Edge_count = edge_count;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (default depth and depth 1).
module tb_input_conditioner;

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;

  input_conditioner_if bus ();
  input_conditioner_if bus1 ();

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  input_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sample one time unit after each rising edge, well clear of it.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic apply_reset;
    #2 Reset = 1'b1;
    #3;
    tick(2);
    #2 Reset = 1'b0;
  endtask

  task automatic test_reset;
    bus.D_raw  = 1'b0;
    bus1.D_raw = 1'b0;
    Reset      = 1'b1;
    tick(2);
    checks++;
    if (bus.Q_clean !== 1'b0) begin errors++; $display("[TB] FAIL reset_q: got %b expected 0", bus.Q_clean); end
    checks++;
    if ({bus.Rise, bus.Fall} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {bus.Rise, bus.Fall}); end
    checks++;
    if (bus.Edge_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.Edge_count); end
    #2 Reset = 1'b0;
    tick(3);
  endtask

  task automatic test_rise;
    bus.D_raw = 1'b1;
    tick(5);
    checks++;
    if (bus.Q_clean !== 1'b0) begin errors++; $display("[TB] FAIL rise_early_q: got %b expected 0", bus.Q_clean); end
    tick(1);
    checks++;
    if ({bus.Q_clean, bus.Rise, bus.Fall} !== 3'b110) begin errors++; $display("[TB] FAIL rise_edge5: got q/rise/fall=%b expected 110", {bus.Q_clean, bus.Rise, bus.Fall}); end
    checks++;
    if (bus.Edge_count !== 8'd1) begin errors++; $display("[TB] FAIL rise_count: got %0d expected 1", bus.Edge_count); end
    tick(1);
    checks++;
    if ({bus.Q_clean, bus.Rise} !== 2'b10) begin errors++; $display("[TB] FAIL rise_edge6: got q/rise=%b expected 10", {bus.Q_clean, bus.Rise}); end
  endtask

  task automatic test_fall;
    bus.D_raw = 1'b0;
    tick(5);
    checks++;
    if ({bus.Q_clean, bus.Fall} !== 2'b10) begin errors++; $display("[TB] FAIL fall_early: got q/fall=%b expected 10", {bus.Q_clean, bus.Fall}); end
    tick(1);
    checks++;
    if ({bus.Q_clean, bus.Rise, bus.Fall} !== 3'b001) begin errors++; $display("[TB] FAIL fall_edge5: got q/rise/fall=%b expected 001", {bus.Q_clean, bus.Rise, bus.Fall}); end
    checks++;
    if (bus.Edge_count !== 8'd1) begin errors++; $display("[TB] FAIL fall_count: got %0d expected 1", bus.Edge_count); end
    tick(1);
    checks++;
    if (bus.Fall !== 1'b0) begin errors++; $display("[TB] FAIL fall_width: got %b expected 0", bus.Fall); end
  endtask

  task automatic test_bounce;
    int seen;
    seen = 0;
    apply_reset();
    tick(3);
    bus.D_raw = 1'b1;
    tick(3);
    bus.D_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.Rise === 1'b1 || bus.Q_clean === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL bounce_reject: got %0d cycles high expected 0", seen); end
    checks++;
    if (bus.Edge_count !== 8'd0) begin errors++; $display("[TB] FAIL bounce_count: got %0d expected 0", bus.Edge_count); end
  endtask

  task automatic test_toggle;
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      bus.D_raw = ~bus.D_raw;
      tick(1);
      if (bus.Q_clean !== 1'b0 || bus.Rise !== 1'b0 || bus.Fall !== 1'b0) seen++;
    end
    bus.D_raw = 1'b0;
    tick(8);
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL toggle_stable: got %0d disturbed cycles expected 0", seen); end
    checks++;
    if (bus.Edge_count !== 8'd0) begin errors++; $display("[TB] FAIL toggle_count: got %0d expected 0", bus.Edge_count); end
  endtask

  task automatic test_async_reset;
    int seen;
    seen = 0;
    bus.D_raw = 1'b1;
    tick(7);
    bus.D_raw = 1'b0;
    tick(8);
    // Edge_count is now 1; advance to WAIT_HIGH with counter=3.
    bus.D_raw = 1'b1;
    tick(5);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({bus.Q_clean, bus.Rise, bus.Fall} !== 3'b000) begin errors++; $display("[TB] FAIL async_outputs: got %b expected 000", {bus.Q_clean, bus.Rise, bus.Fall}); end
    checks++;
    if (bus.Edge_count !== 8'd0) begin errors++; $display("[TB] FAIL async_count: got %0d expected 0", bus.Edge_count); end
    bus.D_raw = 1'b0;
    #1 Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.Rise !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0 || bus.Edge_count !== 8'd0) begin errors++; $display("[TB] FAIL async_no_rise: got rise cycles=%0d count=%0d expected 0 0", seen, bus.Edge_count); end
  endtask

  task automatic test_release_high;
    #2 Reset = 1'b1;
    bus.D_raw = 1'b1;
    tick(2);
    #2 Reset = 1'b0;
    tick(5);
    checks++;
    if (bus.Q_clean !== 1'b0) begin errors++; $display("[TB] FAIL release_early: got %b expected 0", bus.Q_clean); end
    tick(1);
    checks++;
    if ({bus.Q_clean, bus.Rise, bus.Edge_count} !== {2'b11, 8'd1}) begin errors++; $display("[TB] FAIL release_rise: got q=%b rise=%b count=%0d expected 1 1 1", bus.Q_clean, bus.Rise, bus.Edge_count); end
    bus.D_raw = 1'b0;
    tick(8);
  endtask

  task automatic test_wrap;
    apply_reset();
    for (int i = 1; i <= 256; i++) begin
      bus.D_raw = 1'b1;
      tick(7);
      if (i == 255) begin
        checks++;
        if (bus.Edge_count !== 8'd255) begin errors++; $display("[TB] FAIL wrap_255: got %0d expected 255", bus.Edge_count); end
      end
      if (i == 256) begin
        checks++;
        if (bus.Edge_count !== 8'd0) begin errors++; $display("[TB] FAIL wrap_256: got %0d expected 0", bus.Edge_count); end
      end
      bus.D_raw = 1'b0;
      tick(7);
    end
  endtask

  task automatic test_depth_one;
    apply_reset();
    tick(3);
    bus1.D_raw = 1'b1;
    tick(2);
    checks++;
    if (bus1.Q_clean !== 1'b0) begin errors++; $display("[TB] FAIL n1_early: got %b expected 0", bus1.Q_clean); end
    tick(1);
    checks++;
    if ({bus1.Q_clean, bus1.Rise, bus1.Edge_count} !== {2'b11, 8'd1}) begin errors++; $display("[TB] FAIL n1_rise: got q=%b rise=%b count=%0d expected 1 1 1", bus1.Q_clean, bus1.Rise, bus1.Edge_count); end
    tick(1);
    checks++;
    if ({bus1.Q_clean, bus1.Rise} !== 2'b10) begin errors++; $display("[TB] FAIL n1_rise_width: got %b expected 10", {bus1.Q_clean, bus1.Rise}); end
    bus1.D_raw = 1'b0;
    tick(3);
    checks++;
    if ({bus1.Q_clean, bus1.Fall} !== 2'b01) begin errors++; $display("[TB] FAIL n1_fall: got q/fall=%b expected 01", {bus1.Q_clean, bus1.Fall}); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_rise();
    test_fall();
    test_bounce();
    test_toggle();
    test_async_reset();
    test_release_high();
    test_wrap();
    test_depth_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized samples required to accept a level change (legal range 1..255).
REQ-002 Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 D_raw  input  1  asynchronous raw input (switch/key), may bounce.
REQ-005 Q_clean  output  1  debounced, synchronized level; drives the D input of the downstream flip-flop stage.
REQ-006 Rise  output  1  one-cycle pulse when Q_clean goes 0->1.
REQ-007 Fall  output  1  one-cycle pulse when Q_clean goes 1->0.
REQ-008 Edge_count  output  8  count of accepted rising transitions, wraps 255->0.

Function
REQ-009 D_raw SHALL pass through a two-flop synchronizer; the second flop output is the sample S, and nothing else reads D_raw.
REQ-010 FSM states SHALL be STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-011 STABLE_LOW: S=1 -> WAIT_HIGH with counter=1; S=0 -> stay, counter=0.
REQ-012 WAIT_HIGH: S=0 -> STABLE_LOW, counter=0 (bounce rejected, no pulse); S=1 and counter=DEBOUNCE_CYCLES-1 -> STABLE_HIGH; else counter+1.
REQ-013 STABLE_HIGH/WAIT_LOW SHALL mirror REQ-011/012 with levels inverted.
REQ-014 For DEBOUNCE_CYCLES=1, STABLE_x SHALL go directly to the opposite STABLE state on the first differing sample, bypassing WAIT.
REQ-015 Q_clean SHALL be registered: 1 in STABLE_HIGH and WAIT_LOW, 0 otherwise.
REQ-016 Latency: D_raw stable at new level from before edge 0 -> Q_clean changes at edge DEBOUNCE_CYCLES+1 (edge 5 for default).
REQ-017 Rise/Fall SHALL be registered, asserted exactly in the cycle following the edge at which Q_clean changes, never both, never longer than one cycle.
REQ-018 Edge_count SHALL increment on the same edge that asserts Rise; 255 wraps to 0 with no flag.
REQ-019 Counter width SHALL be 8 bits; it SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-020 Input toggling every cycle indefinitely SHALL keep Q_clean, Rise, Fall, Edge_count unchanged.

Reset
REQ-021 Reset asserted SHALL immediately force synchronizer flops=0, state=STABLE_LOW, counter=0, Q_clean=0, Rise=0, Fall=0, Edge_count=0, independent of Clk.
REQ-022 Reset mid-WAIT SHALL discard the partial count; no pulse SHALL be produced by the aborted transition.
REQ-023 After deassertion with D_raw=1, a full debounce (REQ-016) SHALL be required before Q_clean=1 and Rise pulses.

Structure
REQ-024 Shared package cond_pkg SHALL hold the state enumeration and the counter-width constant (8).
REQ-025 The synchronizer SHALL be a sub-module sync_2ff (ports Clk, Reset, D, Q), reusable by other stages.
REQ-026 The FSM, counter, pulse and edge-count logic SHALL reside in input_conditioner.

Verification
REQ-027 Default N=4, Reset then D_raw 0->1 before edge 0 held -> Q_clean=1 and Rise=1 after edge 5, Rise=0 after edge 6, Edge_count=1.
REQ-028 D_raw high for 3 synchronized samples then low -> Q_clean stays 0, Rise never asserts, Edge_count=0.
REQ-029 Q_clean=1, D_raw 1->0 held -> Fall pulses one cycle after edge 5 relative to the change, Edge_count unchanged.
REQ-030 256 accepted rising transitions from reset -> Edge_count reads 0 after the 256th, 255 after the 255th.
REQ-031 Reset asserted asynchronously while in WAIT_HIGH with counter=3 -> all outputs 0 without a clock edge; no Rise after release with D_raw=0.
REQ-032 DEBOUNCE_CYCLES=1, D_raw 0->1 before edge 0 -> Q_clean=1 and Rise=1 after edge 2.
